// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the EX stage that drives it.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // True for DIV and DIVU.
  function automatic logic is_div_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the two-complement operations MULT and DIV.
  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: radix-2^MUL_STEP shift-add multiply and
// restoring divide sharing one accumulator, one add/sub and one counter.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div0_o
);

  localparam int unsigned CNT_W    = $clog2(DATA_W) + 1;
  localparam int unsigned ACC_W    = 2 * DATA_W;
  localparam int unsigned PW       = DATA_W + MUL_STEP;
  localparam int unsigned AW       = DATA_W + MUL_STEP + 1;
  localparam int unsigned MUL_ITER = DATA_W / MUL_STEP;

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q;
  mdu_op_e           op_in;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] opnd_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              div0_q;

  logic              accept;
  logic              step;
  logic              finish;

  logic              div_in;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  logic              div_q;
  logic [PW-1:0]     partial;
  logic [AW-1:0]     add_a;
  logic [AW-1:0]     add_b;
  logic [AW-1:0]     add_res;
  logic [ACC_W-1:0]  acc_step;
  logic [ACC_W-1:0]  prod;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  assign op_in  = mdu_op_e'(op_i);
  assign div_in = is_div_op(op_in);
  assign a_neg  = is_signed_op(op_in) && a_i[DATA_W-1];
  assign b_neg  = is_signed_op(op_in) && b_i[DATA_W-1];
  assign a_mag  = a_neg ? (~a_i + DATA_W'(1)) : a_i;
  assign b_mag  = b_neg ? (~b_i + DATA_W'(1)) : b_i;
  assign div_q  = is_div_op(op_q);

  // Next-state and control strobes; cancel always wins once an op is in flight.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !cancel_i) begin
          accept  = 1'b1;
          state_d = (div_in && (b_i == '0)) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Partial product of the multiplicand with the low MUL_STEP multiplier bits.
  always_comb begin
    partial = '0;
    for (int k = 0; k < int'(MUL_STEP); k++) begin
      if (acc_q[k]) partial = partial + (PW'(opnd_q) << k);
    end
  end

  // Shared adder: accumulates partial products, or trial-subtracts the divisor.
  always_comb begin
    if (div_q) begin
      add_a = AW'({acc_q[ACC_W-1:DATA_W], acc_q[DATA_W-1]});
      add_b = ~AW'(opnd_q);
    end else begin
      add_a = AW'(acc_q[ACC_W-1:DATA_W]);
      add_b = AW'(partial);
    end
    add_res = add_a + add_b + AW'(div_q);
  end

  // One iteration of the accumulator; a negative trial difference restores.
  always_comb begin
    if (!div_q) begin
      acc_step = {add_res[PW-1:0], acc_q[DATA_W-1:MUL_STEP]};
    end else if (add_res[AW-1]) begin
      acc_step = {acc_q[ACC_W-2:0], 1'b0};
    end else begin
      acc_step = {add_res[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end
  end

  // Sign correction of the magnitude result, or the divide-by-zero pattern.
  always_comb begin
    prod   = neg_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
    res_hi = prod[ACC_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (div0_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else if (div_q) begin
      res_lo = neg_res_q ? (~acc_q[DATA_W-1:0] + DATA_W'(1)) : acc_q[DATA_W-1:0];
      res_hi = neg_rem_q ? (~acc_q[ACC_W-1:DATA_W] + DATA_W'(1)) : acc_q[ACC_W-1:DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Working registers: operand capture on accept, iteration in CALC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= OP_MULT;
      a_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (accept) begin
      op_q      <= op_in;
      a_q       <= a_i;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      div0_q    <= div_in && (b_i == '0);
      cnt_q     <= div_in ? CNT_W'(DATA_W) : CNT_W'(MUL_ITER);
      if (div_in) begin
        acc_q  <= {DATA_W'(0), a_mag};
        opnd_q <= b_mag;
      end else begin
        acc_q  <= {DATA_W'(0), b_mag};
        opnd_q <= a_mag;
      end
    end else if (step) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Registered outputs; results and div0 only change on entry to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      div0_o  <= 1'b0;
    end else begin
      busy_o  <= (state_d != ST_IDLE);
      valid_o <= finish;
      if (finish) begin
        hi_o   <= res_hi;
        lo_o   <= res_lo;
        div0_o <= div0_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (DATA_W=32, MUL_STEP=2).
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div0_o;

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int v0;

  mul_div_unit #(.DATA_W(32), .MUL_STEP(2)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cancel_i(cancel_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .div0_o  (div0_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (valid_o) valid_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                            input logic d0);
    check({tag, "_hi"}, 64'(hi_o), 64'(hi));
    check({tag, "_lo"}, 64'(lo_o), 64'(lo));
    check({tag, "_div0"}, 64'(div0_o), 64'(d0));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_d0);
    int n;
    bit got;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      n++;
      if (valid_o) got = 1'b1;
    end
    check({tag, "_valid"}, 64'(got), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_outs(tag, exp_hi, exp_lo, exp_d0);
    @(posedge clk_i); #1;
    check({tag, "_strobe"}, 64'(valid_o), 64'd0);
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0; cancel_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check_outs("rst", 32'h0, 32'h0, 1'b0);
    @(negedge clk_i) rst_i = 1'b0;

    run_op("mult",     2'b00, 32'hFFFF_FFFF, 32'd2, 18, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("multu",    2'b01, 32'hFFFF_FFFF, 32'd2, 18, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_z",   2'b11, 32'd100, 32'd0, 2, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 18, 32'h0, 32'd15, 1'b0);
    run_op("div_z_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // Cancel during the fifth CALC cycle of a divide.
    v0 = valid_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 cancel_i = 1'b1;
    @(posedge clk_i); #1;
    cancel_i = 1'b0;
    check("cancel_busy", 64'(busy_o), 64'd0);
    repeat (40) @(posedge clk_i);
    #1;
    check("cancel_novalid", 64'(valid_cnt), 64'(v0));
    check_outs("cancel_hold", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_3_5", 2'b01, 32'd3, 32'd5, 18, 32'h0, 32'd15, 1'b0);
    check("cancel_one_valid", 64'(valid_cnt), 64'(v0 + 1));

    // Cancel in FIX (divide-by-zero skips CALC).
    v0 = valid_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd9; b_i = 32'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("fix_busy", 64'(busy_o), 64'd1);
    cancel_i = 1'b1;
    @(posedge clk_i); #1;
    cancel_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("fix_cancel_novalid", 64'(valid_cnt), 64'(v0));
    check_outs("fix_cancel_hold", 32'h0, 32'd15, 1'b0);

    // Start with cancel in IDLE is ignored.
    @(negedge clk_i);
    start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b01; a_i = 32'd2; b_i = 32'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    check("idle_cancel_busy", 64'(busy_o), 64'd0);

    // Reset pulsed during the tenth CALC cycle.
    v0 = valid_cnt;
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_valid", 64'(valid_o), 64'd0);
    check_outs("mrst", 32'h0, 32'h0, 1'b0);
    @(negedge clk_i) rst_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    check("mrst_novalid", 64'(valid_cnt), 64'(v0));
    run_op("divu_after_rst", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
